// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback path.
// Holds register/data widths and the pending-write entry type.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending register writes.
// Exposes raw slots so the owner can search them for forwarding.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                pushEntry,
  output wb_entry_t                slots [DEPTH],
  output logic [$clog2(DEPTH)-1:0] headPtr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] tailPtr;

  // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[tailPtr] <= pushEntry;
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU results until the regfile accepts them,
// and forwards the youngest pending value to decode-stage readers.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [REG_ADDR_W-1:0] res_dest_i,
  input  logic [DATA_W-1:0]     res_data_i,
  output logic                  wr_en_o,
  input  logic                  wr_ready_i,
  output logic [REG_ADDR_W-1:0] wr_reg_o,
  output logic [DATA_W-1:0]     wr_data_o,
  input  logic [REG_ADDR_W-1:0] byp_reg1_i,
  input  logic [REG_ADDR_W-1:0] byp_reg2_i,
  output logic                  byp_hit1_o,
  output logic                  byp_hit2_o,
  output logic [DATA_W-1:0]     byp_data1_o,
  output logic [DATA_W-1:0]     byp_data2_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t     slots [DEPTH];
  wb_entry_t     pushEntry;
  logic [PW-1:0] headPtr;
  logic [CW-1:0] count;
  logic          pushFire;
  logic          popFire;
  logic [PW-1:0] idx;

  assign pushEntry = '{dest: res_dest_i, data: res_data_i};

  // Ready comes only from stored occupancy, never from this cycle's pop.
  assign res_ready_o = count < FULL;
  assign pushFire    = res_valid_i & res_ready_o;
  assign wr_en_o     = count != '0;
  assign popFire     = wr_en_o & wr_ready_i;
  assign count_o     = count;

  assign wr_reg_o  = wr_en_o ? slots[headPtr].dest : '0;
  assign wr_data_o = wr_en_o ? slots[headPtr].data : '0;

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk       (clk),
    .rst_i     (rst_i),
    .push      (pushFire),
    .pop       (popFire),
    .pushEntry (pushEntry),
    .slots     (slots),
    .headPtr   (headPtr),
    .count     (count)
  );

  // Walk oldest to youngest so the last match is the freshest value.
  always_comb begin
    byp_hit1_o  = 1'b0;
    byp_hit2_o  = 1'b0;
    byp_data1_o = '0;
    byp_data2_o = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if (CW'(i) < count) begin
        if (slots[idx].dest == byp_reg1_i) begin
          byp_hit1_o  = 1'b1;
          byp_data1_o = slots[idx].data;
        end
        if (slots[idx].dest == byp_reg2_i) begin
          byp_hit2_o  = 1'b1;
          byp_data2_o = slots[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 0;
  logic       rst_i;
  logic       res_valid_i;
  logic       res_ready_o;
  logic [2:0] res_dest_i;
  logic [7:0] res_data_i;
  logic       wr_en_o;
  logic       wr_ready_i;
  logic [2:0] wr_reg_o;
  logic [7:0] wr_data_o;
  logic [2:0] byp_reg1_i;
  logic [2:0] byp_reg2_i;
  logic       byp_hit1_o;
  logic       byp_hit2_o;
  logic [7:0] byp_data1_o;
  logic [7:0] byp_data2_o;
  logic [2:0] count_o;

  int nChecks = 0;
  int nFail   = 0;

  wb_entry_t mq [$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_dest_i  (res_dest_i),
    .res_data_i  (res_data_i),
    .wr_en_o     (wr_en_o),
    .wr_ready_i  (wr_ready_i),
    .wr_reg_o    (wr_reg_o),
    .wr_data_o   (wr_data_o),
    .byp_reg1_i  (byp_reg1_i),
    .byp_reg2_i  (byp_reg2_i),
    .byp_hit1_o  (byp_hit1_o),
    .byp_hit2_o  (byp_hit2_o),
    .byp_data1_o (byp_data1_o),
    .byp_data2_o (byp_data2_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] bypass(logic [2:0] r);
    logic [8:0] res;
    res = '0;
    foreach (mq[i])
      if (mq[i].dest == r) res = {1'b1, mq[i].data};
    return res;
  endfunction

  // Reference model: a plain FIFO queue updated on each rising edge.
  bit pushOk, popOk;
  always @(posedge clk) begin
    if (!rst_i) begin
      pushOk = res_valid_i && (mq.size() < DEPTH);
      popOk  = (mq.size() > 0) && wr_ready_i;
      if (popOk) void'(mq.pop_front());
      if (pushOk) mq.push_back('{dest: res_dest_i, data: res_data_i});
    end
  end

  logic [8:0] b1, b2;
  always @(negedge clk) begin
    b1 = bypass(byp_reg1_i);
    b2 = bypass(byp_reg2_i);
    check("m_count", 32'(count_o), 32'(mq.size()));
    check("m_ready", 32'(res_ready_o), 32'(mq.size() < DEPTH));
    check("m_wr_en", 32'(wr_en_o), 32'(mq.size() > 0));
    check("m_wr_reg", 32'(wr_reg_o),
          mq.size() > 0 ? 32'(mq[0].dest) : 32'd0);
    check("m_wr_data", 32'(wr_data_o),
          mq.size() > 0 ? 32'(mq[0].data) : 32'd0);
    check("m_hit1", 32'(byp_hit1_o), 32'(b1[8]));
    check("m_data1", 32'(byp_data1_o), 32'(b1[7:0]));
    check("m_hit2", 32'(byp_hit2_o), 32'(b2[8]));
    check("m_data2", 32'(byp_data2_o), 32'(b2[7:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    res_valid_i = 0;
    wr_ready_i  = 1;
    n = 0;
    while (count_o != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(count_o), 32'd0);
  endtask

  initial begin
    rst_i = 1;
    res_valid_i = 0;
    res_dest_i = 0;
    res_data_i = 0;
    wr_ready_i = 0;
    byp_reg1_i = 0;
    byp_reg2_i = 0;
    #12;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(res_ready_o), 32'd1);
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_hit1", 32'(byp_hit1_o), 32'd0);
    tick();
    rst_i = 0;

    // Single push into empty queue, immediately written
    res_valid_i = 1; res_dest_i = 3; res_data_i = 8'h5A; wr_ready_i = 1;
    tick();
    res_valid_i = 0;
    check("lat_wr_en", 32'(wr_en_o), 32'd1);
    check("lat_wr_reg", 32'(wr_reg_o), 32'd3);
    check("lat_wr_data", 32'(wr_data_o), 32'h5A);
    check("lat_count", 32'(count_o), 32'd1);
    tick();
    check("lat_count0", 32'(count_o), 32'd0);
    check("lat_wr_en0", 32'(wr_en_o), 32'd0);

    // Overfill: fifth push dropped
    wr_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      res_valid_i = 1; res_dest_i = 3'(i); res_data_i = 8'(8'h10 + i);
      tick();
    end
    res_valid_i = 0;
    check("full_count", 32'(count_o), 32'd4);
    check("full_ready", 32'(res_ready_o), 32'd0);
    wr_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      check("full_order_reg", 32'(wr_reg_o), 32'(i));
      check("full_order_data", 32'(wr_data_o), 32'h10 + 32'(i));
      tick();
    end
    check("full_empty", 32'(count_o), 32'd0);

    // Youngest-match bypass; offered result is not forwarded
    wr_ready_i = 0;
    res_valid_i = 1; res_dest_i = 2; res_data_i = 8'h11; tick();
    res_dest_i = 2; res_data_i = 8'h22; tick();
    res_valid_i = 0;
    byp_reg1_i = 2; byp_reg2_i = 5; #1;
    check("byp_hit1", 32'(byp_hit1_o), 32'd1);
    check("byp_data1", 32'(byp_data1_o), 32'h22);
    check("byp_hit2", 32'(byp_hit2_o), 32'd0);
    check("byp_data2", 32'(byp_data2_o), 32'd0);
    res_valid_i = 1; res_dest_i = 5; res_data_i = 8'h77; #1;
    check("byp_same_cycle", 32'(byp_hit2_o), 32'd0);
    tick();
    res_valid_i = 0;
    check("byp_after_push", 32'(byp_data2_o), 32'h77);
    drain();

    // Steady push/pop at two entries, wrapping the pointers
    wr_ready_i = 0;
    res_valid_i = 1; res_dest_i = 1; res_data_i = 8'hA0; tick();
    res_dest_i = 2; res_data_i = 8'hA1; tick();
    wr_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      res_dest_i = 3'(i); res_data_i = 8'(8'hB0 + i);
      tick();
      check("pair_count", 32'(count_o), 32'd2);
    end
    res_valid_i = 0;
    check("pair_head_reg", 32'(wr_reg_o), 32'd0);
    check("pair_head_data", 32'(wr_data_o), 32'hB8);
    drain();

    // Asynchronous reset with three pending entries
    wr_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      res_valid_i = 1; res_dest_i = 3'(4 + i); res_data_i = 8'(8'hC0 + i);
      tick();
    end
    res_valid_i = 0;
    byp_reg1_i = 4;
    #2;
    rst_i = 1;
    mq.delete();
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_wr_en", 32'(wr_en_o), 32'd0);
    check("arst_wr_reg", 32'(wr_reg_o), 32'd0);
    check("arst_wr_data", 32'(wr_data_o), 32'd0);
    check("arst_hit1", 32'(byp_hit1_o), 32'd0);
    check("arst_data1", 32'(byp_data1_o), 32'd0);
    check("arst_ready", 32'(res_ready_o), 32'd1);
    tick();
    rst_i = 0;
    wr_ready_i = 1;
    tick();
    check("arst_no_write", 32'(wr_en_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      res_valid_i = 1'($urandom_range(0, 99) < 60);
      wr_ready_i  = 1'($urandom_range(0, 99) < 50);
      res_dest_i  = 3'($urandom);
      res_data_i  = 8'($urandom);
      byp_reg1_i  = 3'($urandom);
      byp_reg2_i  = 3'($urandom);
      tick();
    end
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
